// File: rtl/crc_hash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_hash_pkg
// Purpose  : Shared constants for the CRC-64 hash sequencer and its step cell:
//            the tap polynomial, the default parity width and the FSM state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package crc_hash_pkg;

    // Default parity width of the step cell and sequencer.
    localparam int HASH_LENGTH_DEFAULT = 64;

    // Tap polynomial. Literal index 0 is the MSB, so literal index i lives at
    // vector bit [64-i]. Bit i >= 1 selects whether parity[i] takes feedback.
    localparam logic [64:0] HASH_VALUE =
        65'b11001001011011000101011110010101110101111000011100001111010000101;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : crc_hash_pkg
`default_nettype wire

// File: rtl/crc_hash_step.sv
`default_nettype none
// ============================================================================
// Module   : crc_hash_step
// Purpose  : One bit-serial CRC-64 LFSR step, purely combinational.
// Ports    : i_msg    - message bit consumed by this step
//            i_parity - current parity
//            o_parity - parity after absorbing i_msg
// Revision : 1.0 - initial release
// ============================================================================
module crc_hash_step
    import crc_hash_pkg::*;
#(
    parameter int HASH_LENGTH = HASH_LENGTH_DEFAULT
) (
    input  logic                   i_msg,
    input  logic [HASH_LENGTH-1:0] i_parity,
    output logic [HASH_LENGTH-1:0] o_parity
);

    logic w_fb;

    assign w_fb        = i_msg ^ i_parity[HASH_LENGTH-1];
    assign o_parity[0] = w_fb;

    // Literal index i of the polynomial sits at vector bit [HASH_LENGTH-i].
    for (genvar i = 1; i < HASH_LENGTH; i++) begin : g_tap
        assign o_parity[i] = i_parity[i-1] ^ (HASH_VALUE[HASH_LENGTH-i] & w_fb);
    end

endmodule : crc_hash_step
`default_nettype wire

// File: rtl/crc_hash_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crc_hash_sequencer
// Purpose  : Runs multi-word messages through PARALLEL chained CRC-64 step
//            cells per cycle (MSB first) and presents the final hash on a
//            valid/ready output.
// Ports    : i_clk, i_RESET (sync, active high)
//            i_start                 - opens a message (IDLE only)
//            i_data/i_valid/i_last   - word input, accepted when o_ready
//            o_ready                 - high only in ACCEPT
//            o_hash/o_hash_valid     - final hash, held until i_hash_ready
//            i_hash_ready            - consumer accept
//            o_busy                  - high outside IDLE
// Config   : CRC_HASH_SEQ_FINAL_INVERT_EN - when defined, o_hash is the
//            inverted parity, registered on entry to DONE.
// Revision : 1.0 - initial release
// ============================================================================
module crc_hash_sequencer
    import crc_hash_pkg::*;
#(
    parameter int HASH_LENGTH = HASH_LENGTH_DEFAULT,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLEL    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_RESET,
    input  logic                   i_start,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_valid,
    input  logic                   i_last,
    output logic                   o_ready,
    output logic [HASH_LENGTH-1:0] o_hash,
    output logic                   o_hash_valid,
    input  logic                   i_hash_ready,
    output logic                   o_busy
);

    localparam int BEATS  = DATA_WIDTH / PARALLEL;
    // Keep the counter at least one bit wide when a word takes a single beat.
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [1:0]             state_q,  state_d;
    logic [DATA_WIDTH-1:0]  shreg_q,  shreg_d;
    logic                   last_q,   last_d;
    logic [BEAT_W-1:0]      beat_q,   beat_d;
    logic [HASH_LENGTH-1:0] parity_q, parity_d;

    logic                   w_final_beat;
    logic [HASH_LENGTH-1:0] w_chain [0:PARALLEL];

    // ------------------------------------------------------------------------
    // Step chain: stage k consumes shreg bit DATA_WIDTH-1-k.
    // ------------------------------------------------------------------------
    assign w_chain[0] = parity_q;

    for (genvar k = 0; k < PARALLEL; k++) begin : g_step
        crc_hash_step #(
            .HASH_LENGTH (HASH_LENGTH)
        ) u_step (
            .i_msg    (shreg_q[DATA_WIDTH-1-k]),
            .i_parity (w_chain[k]),
            .o_parity (w_chain[k+1])
        );
    end

    assign w_final_beat = (state_q == ST_SHIFT) && (beat_q == LAST_BEAT);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        last_d   = last_q;
        beat_d   = beat_q;
        parity_d = parity_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d  = ST_ACCEPT;
                    parity_d = '0;
                end
            end
            ST_ACCEPT: begin
                if (i_valid) begin
                    shreg_d = i_data;
                    last_d  = i_last;
                    beat_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                parity_d = w_chain[PARALLEL];
                shreg_d  = shreg_q << PARALLEL;
                if (beat_q == LAST_BEAT) begin
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                if (i_hash_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            last_q   <= 1'b0;
            beat_q   <= '0;
            parity_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            parity_q <= parity_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ready      = (state_q == ST_ACCEPT);
    assign o_hash_valid = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);

`ifdef CRC_HASH_SEQ_FINAL_INVERT_EN
    logic [HASH_LENGTH-1:0] hash_q, hash_d;

    // Capture the inverted result on the beat that enters DONE so o_hash is
    // stable for the whole DONE window.
    always_comb begin
        hash_d = hash_q;
        if (w_final_beat && last_q) begin
            hash_d = ~w_chain[PARALLEL];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            hash_q <= '0;
        end else begin
            hash_q <= hash_d;
        end
    end

    assign o_hash = hash_q;
`else
    // Parity does not move in DONE, so it can drive the output directly.
    assign o_hash = parity_q;
`endif

endmodule : crc_hash_sequencer
`default_nettype wire
